cam_capture_ctrl: RTL and testbench

Frame-capture sequencer that sits between the OV7670 pixel-capture stage and the frame-buffer write port, in the `pclk` domain. It arms capture on request, runs either single-shot or continuous, and gates the capture stage's write strobe so that only whole frames reach the buffer. It also counts pixels and lines, checks the frame geometry, and reports frame completion and errors to the display/control side.

---
 rtl/cam_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - frame-capture sequencer gating camera pixel writes into the frame buffer
`timescale 1ns/1ps
module cam_capture_ctrl #(
  parameter int AW   = 15,
  parameter int H_PX = 160,
  parameter int V_LN = 120
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       vsync,
  input  logic       href,
  input  logic       px_wr_in,
  output logic       mem_wr,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [7:0] line_cnt,
  output logic [7:0] px_cnt,
  output logic [7:0] frame_cnt,
  output logic       err_len,
  output logic       err_lines
);

  // Pixel budget per frame never exceeds what the buffer can address.
  localparam int          FB_WORDS = 1 << AW;
  localparam int          PX_MAX   = (H_PX * V_LN < FB_WORDS) ? H_PX * V_LN : FB_WORDS;
  localparam logic [15:0] TOT_MAX  = 16'(PX_MAX);
  localparam logic [7:0]  H_LEN    = 8'(H_PX);
  localparam logic [7:0]  V_LEN    = 8'(V_LN);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        vsync_q, href_q, wr_q;
  logic        cont_r, full, ferr;
  logic [15:0] tot;

  logic        vs_fall, vs_rise, hr_fall, px_ev;
  logic        px_take, ovf, len_bad, ferr_fin;
  logic [7:0]  px_len, line_nxt, line_fin;

  assign vs_fall = ~vsync & vsync_q;
  assign vs_rise = vsync & ~vsync_q;
  assign hr_fall = ~href & href_q;
  assign px_ev   = px_wr_in & ~wr_q;

  assign px_take  = px_ev & (tot < TOT_MAX);
  assign ovf      = px_ev & ~px_take;
  // A pixel landing with the href fall belongs to the line that is ending.
  assign px_len   = (px_take && px_cnt != 8'hFF) ? px_cnt + 8'd1 : px_cnt;
  assign len_bad  = hr_fall & (px_len != H_LEN);
  assign line_nxt = (line_cnt != 8'hFF) ? line_cnt + 8'd1 : line_cnt;
  assign line_fin = hr_fall ? line_nxt : line_cnt;
  assign ferr_fin = ferr | ovf | len_bad;

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  // The overflowing pixel itself is suppressed, not just the ones after it.
  assign mem_wr     = px_wr_in & (state == S_CAPTURE) & ~full & ~ovf;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && !stop) state_nxt = S_ARM;
      S_ARM:     if (stop) state_nxt = S_IDLE;
                 else if (vs_fall) state_nxt = S_CAPTURE;
      S_CAPTURE: if (vs_rise) state_nxt = S_DONE;
      S_DONE:    state_nxt = cont_r ? S_ARM : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q   <= 1'b1;
      href_q    <= 1'b0;
      wr_q      <= 1'b0;
      cont_r    <= 1'b0;
      full      <= 1'b0;
      ferr      <= 1'b0;
      tot       <= 16'd0;
      frame_ok  <= 1'b0;
      line_cnt  <= 8'd0;
      px_cnt    <= 8'd0;
      frame_cnt <= 8'd0;
      err_len   <= 1'b0;
      err_lines <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      wr_q    <= px_wr_in;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            cont_r    <= cont;
            err_len   <= 1'b0;
            err_lines <= 1'b0;
          end
        end
        S_ARM: begin
          if (!stop && vs_fall) begin
            line_cnt <= 8'd0;
            px_cnt   <= 8'd0;
            ferr     <= 1'b0;
            full     <= 1'b0;
            tot      <= 16'd0;
          end
        end
        S_CAPTURE: begin
          if (px_take) tot <= tot + 16'd1;
          if (ovf) begin
            full      <= 1'b1;
            err_lines <= 1'b1;
          end
          if (hr_fall) begin
            line_cnt <= line_nxt;
            px_cnt   <= 8'd0;
          end else if (px_take) begin
            px_cnt <= px_len;
          end
          if (len_bad) err_len <= 1'b1;
          ferr <= ferr_fin;
          if (stop) cont_r <= 1'b0;
          if (vs_rise) begin
            if (line_fin != V_LEN) err_lines <= 1'b1;
            frame_ok  <= ~ferr_fin & (line_fin == V_LEN);
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - randomized self-checking bench for cam_capture_ctrl
`timescale 1ns/1ps
module tb_cam_capture_ctrl;
  localparam int H      = 10;
  localparam int V      = 6;
  localparam int CAP_PX = H * V;

  logic       pclk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, cont = 1'b0, stop = 1'b0;
  logic       vsync = 1'b1, href = 1'b0, px_wr_in = 1'b0;
  logic       mem_wr, busy, frame_done, frame_ok, err_len, err_lines;
  logic [7:0] line_cnt, px_cnt, frame_cnt;

  cam_capture_ctrl #(.AW(15), .H_PX(H), .V_LN(V)) dut (
    .pclk(pclk), .rst(rst), .start(start), .cont(cont), .stop(stop),
    .vsync(vsync), .href(href), .px_wr_in(px_wr_in),
    .mem_wr(mem_wr), .busy(busy), .frame_done(frame_done), .frame_ok(frame_ok),
    .line_cnt(line_cnt), .px_cnt(px_cnt), .frame_cnt(frame_cnt),
    .err_len(err_len), .err_lines(err_lines)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Stimulus drive values, applied once per cycle.
  bit d_vs = 1'b1, d_hr = 1'b0, d_wr = 1'b0, d_st = 1'b0, d_sp = 1'b0, d_cn = 1'b0;

  // Reference model: capture mode plus per-frame outcome derived from line lengths.
  typedef enum {M_IDLE, M_ARM, M_CAP, M_DONE} mmode_t;
  mmode_t     m_mode;
  bit         m_cont, m_ok, m_elen, m_elin, m_last_acc, m_pvs, m_phr, m_pwr;
  int         m_acc, m_lines;
  logic [7:0] m_fcnt;
  int         lens[$];
  int         line_len[0:15];
  int         g_len;
  int         obs_px;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_mode = M_IDLE; m_cont = 0; m_ok = 0; m_elen = 0; m_elin = 0;
    m_fcnt = 8'd0; m_pvs = 1; m_phr = 0; m_pwr = 0;
    m_acc = 0; m_last_acc = 0; m_lines = 0;
  endfunction

  function automatic void eval_frame();
    int acc = 0;
    bit el = 0, ov = 0;
    foreach (lens[i]) begin
      int c = lens[i];
      if (c > CAP_PX - acc) begin ov = 1; c = CAP_PX - acc; end
      acc += c;
      if (c != H) el = 1;
    end
    m_lines = lens.size();
    m_elen |= el;
    m_elin |= ov || (m_lines != V);
    m_ok = !el && !ov && (m_lines == V);
    m_fcnt++;
  endfunction

  task automatic cyc();
    bit vf, vr, hf, pe, exp_wr;
    vsync = d_vs; href = d_hr; px_wr_in = d_wr; start = d_st; stop = d_sp; cont = d_cn;
    vf = !d_vs && m_pvs;
    vr = d_vs && !m_pvs;
    hf = !d_hr && m_phr;
    pe = d_wr && !m_pwr;
    exp_wr = d_wr && (m_mode == M_CAP) && (pe ? (m_acc < CAP_PX) : m_last_acc);
    @(negedge pclk);
    chk("mem_wr", 16'(mem_wr), 16'(exp_wr));
    chk("busy", 16'(busy), 16'(m_mode != M_IDLE));
    chk("frame_done", 16'(frame_done), 16'(m_mode == M_DONE));
    chk("frame_ok", 16'(frame_ok), 16'(m_ok));
    chk("frame_cnt", 16'(frame_cnt), 16'(m_fcnt));
    if (mem_wr && pe) obs_px++;
    if (m_mode == M_DONE) begin
      chk("line_cnt", 16'(line_cnt), 16'(m_lines));
      chk("px_cnt", 16'(px_cnt), 16'd0);
      chk("err_len", 16'(err_len), 16'(m_elen));
      chk("err_lines", 16'(err_lines), 16'(m_elin));
    end
    if (rst) begin
      m_reset();
    end else begin
      case (m_mode)
        M_IDLE: if (d_st && !d_sp) begin
          m_mode = M_ARM; m_cont = d_cn; m_elen = 0; m_elin = 0;
        end
        M_ARM: if (d_sp) m_mode = M_IDLE;
               else if (vf) begin
                 m_mode = M_CAP; lens.delete(); m_acc = 0; m_last_acc = 0;
               end
        M_CAP: begin
          if (pe) begin
            m_last_acc = (m_acc < CAP_PX);
            if (m_last_acc) m_acc++;
          end
          if (hf) lens.push_back(g_len);
          if (d_sp) m_cont = 0;
          if (vr) begin eval_frame(); m_mode = M_DONE; end
        end
        M_DONE: m_mode = m_cont ? M_ARM : M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      m_pvs = d_vs; m_phr = d_hr; m_pwr = d_wr;
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic hit_reset();
    #2 rst = 1'b1;
    px_wr_in = 1'b1;
    m_reset();
    #1;
    chk("rst_mem_wr", 16'(mem_wr), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_line_cnt", 16'(line_cnt), 16'd0);
    chk("rst_px_cnt", 16'(px_cnt), 16'd0);
    chk("rst_frame_cnt", 16'(frame_cnt), 16'd0);
    chk("rst_err", 16'({err_len, err_lines, frame_ok, frame_done}), 16'd0);
    d_hr = 0; d_wr = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic nominal();
    for (int i = 0; i < 16; i++) line_len[i] = H;
  endtask

  task automatic do_start(input bit c);
    d_st = 1; d_cn = c; d_sp = 0;
    cyc();
    d_st = 0;
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_clr_err_len", 16'(err_len), 16'd0);
    chk("start_clr_err_lines", 16'(err_lines), 16'd0);
  endtask

  // ev_kind: 1 = start pulse, 2 = stop pulse, 3 = async reset, at the head of line ev_line.
  task automatic frame(input int nl, input int ev_line, input int ev_kind, input int exp_px);
    bit late, hold, coin;
    coin = 0;
    obs_px = 0;
    d_vs = 0; d_hr = 0; d_wr = 0;
    cyc();
    repeat ($urandom_range(1, 3)) cyc();
    for (int l = 0; l < nl; l++) begin
      if (l == ev_line) begin
        if (ev_kind == 1) begin d_st = 1; d_cn = 0; end
        else if (ev_kind == 2) d_sp = 1;
        else if (ev_kind == 3) hit_reset();
      end
      g_len = line_len[l];
      late = ($urandom_range(0, 3) == 0);
      hold = (l != nl - 1) && ($urandom_range(0, 1) == 1);
      coin = (l == nl - 1) && ($urandom_range(0, 1) == 1);
      for (int p = 0; p < g_len; p++) begin
        d_hr = 1; d_wr = 0;
        cyc();
        d_st = 0; d_sp = 0;
        d_wr = 1;
        if (late && p == g_len - 1) begin d_hr = 0; d_vs = coin; end
        cyc();
      end
      if (!(late && g_len > 0)) begin
        d_hr = 0; d_wr = hold; d_vs = coin;
        cyc();
      end
      d_hr = 0; d_wr = hold;
      repeat ($urandom_range(1, 2)) cyc();
    end
    d_vs = 1; d_hr = 0; d_wr = 0;
    repeat (4) cyc();
    if (exp_px >= 0) chk("px_written", 16'(obs_px), 16'(exp_px));
  endtask

  initial begin
    int nl, sum;
    m_reset();
    nominal();
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_mem_wr", 16'(mem_wr), 16'd0);
    chk("reset_counts", 16'({line_cnt, px_cnt}), 16'd0);
    chk("reset_flags", 16'({frame_cnt, err_len, err_lines, frame_ok, frame_done}), 16'd0);
    rst = 1'b0;
    repeat (2) cyc();

    // single-shot: only the first of two frames is written
    do_start(0);
    frame(V, -1, 0, CAP_PX);
    frame(V, -1, 0, 0);
    chk("single_frame_cnt", 16'(frame_cnt), 16'd1);
    chk("single_idle", 16'(busy), 16'd0);

    // continuous, stop during the third frame
    do_start(1);
    frame(V, -1, 0, CAP_PX);
    frame(V, -1, 0, CAP_PX);
    frame(V, 2, 2, CAP_PX);
    frame(V, -1, 0, 0);
    chk("cont_frame_cnt", 16'(frame_cnt), 16'd4);
    chk("cont_idle", 16'(busy), 16'd0);

    // arming mid-frame waits for the next vsync fall
    frame(V, 2, 1, 0);
    frame(V, -1, 0, CAP_PX);
    chk("midarm_ok", 16'(frame_ok), 16'd1);

    // short line
    do_start(0);
    line_len[4] = H - 1;
    frame(V, -1, 0, CAP_PX - 1);
    chk("short_line_err_len", 16'(err_len), 16'd1);
    chk("short_line_ok", 16'(frame_ok), 16'd0);
    nominal();

    // missing line
    do_start(0);
    frame(V - 1, -1, 0, CAP_PX - H);
    chk("short_frame_err_lines", 16'(err_lines), 16'd1);
    chk("short_frame_err_len", 16'(err_len), 16'd0);

    // overflow: one extra line is never written
    do_start(0);
    frame(V + 1, -1, 0, CAP_PX);
    chk("ovf_err_lines", 16'(err_lines), 16'd1);
    chk("ovf_ok", 16'(frame_ok), 16'd0);
    chk("ovf_frame_cnt", 16'(frame_cnt), 16'd8);

    // async reset at line 3, then a clean capture
    do_start(0);
    frame(V, 3, 3, 3 * H);
    do_start(0);
    frame(V, -1, 0, CAP_PX);
    chk("post_rst_ok", 16'(frame_ok), 16'd1);
    chk("post_rst_frame_cnt", 16'(frame_cnt), 16'd1);

    // randomized geometry in continuous mode
    do_start(1);
    for (int f = 0; f < 6; f++) begin
      nl = V - 1 + int'($urandom_range(0, 2));
      sum = 0;
      for (int i = 0; i < nl; i++) begin
        line_len[i] = H;
        if ($urandom_range(0, 7) == 0) line_len[i] = ($urandom_range(0, 1) == 1) ? H + 1 : H - 1;
        sum += line_len[i];
      end
      frame(nl, -1, 0, (sum < CAP_PX) ? sum : CAP_PX);
    end
    d_sp = 1;
    cyc();
    d_sp = 0;
    cyc();
    chk("final_idle", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
